// File: rtl/seg_scan_timer_if.sv
// Control and display-select bundle between a seg_scan_timer and its owner.
// The owner programs the divider, and the timer returns the strobe, the square wave and the digit select.
interface seg_scan_timer_if #(
   parameter int CNT_WIDTH  = 16,
   parameter int NUM_DIGITS = 4,
   parameter int IDX_WIDTH  = 2
);
   logic                  enable;
   logic                  div_load;
   logic [CNT_WIDTH-1:0]  div_value;
   logic                  tick;
   logic                  clk_out;
   logic [IDX_WIDTH-1:0]  digit_idx;
   logic [NUM_DIGITS-1:0] anode;

   modport master (
      output enable, div_load, div_value,
      input  tick, clk_out, digit_idx, anode
   );

   modport slave (
      input  enable, div_load, div_value,
      output tick, clk_out, digit_idx, anode
   );
endinterface

// File: rtl/seg_scan_timer.sv
// Programmable refresh divider for a multiplexed seven-segment display.
// It produces a tick strobe, a 50% square wave and a rotating active-low anode select.
module seg_scan_timer #(
   parameter int CNT_WIDTH   = 16,
   parameter int DEFAULT_DIV = 49999,
   parameter int NUM_DIGITS  = 4,
   parameter int IDX_WIDTH   = 2
) (
   input  logic             clk,
   input  logic             reset,
   seg_scan_timer_if.slave  bus
);

   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [CNT_WIDTH-1:0] div_q, div_d;
   logic                 tick_q, tick_d;
   logic                 clk_out_q, clk_out_d;
   logic [IDX_WIDTH-1:0] digit_q, digit_d;

   always_comb begin
      // NOTE: every _d gets a hold value first so that no path through the if-chain infers a latch.
      count_d   = count_q;
      div_d     = div_q;
      tick_d    = 1'b0;
      clk_out_d = clk_out_q;
      digit_d   = digit_q;

      if (bus.div_load) begin
         div_d   = bus.div_value;
         count_d = '0;
      end else if (bus.enable) begin
         if (count_q == div_q) begin
            count_d   = '0;
            tick_d    = 1'b1;
            clk_out_d = ~clk_out_q;
            // Explicit wrap keeps the index legal when NUM_DIGITS is not a power of two.
            if (digit_q == IDX_WIDTH'(NUM_DIGITS - 1)) digit_d = '0;
            else                                       digit_d = digit_q + IDX_WIDTH'(1);
         end else begin
            count_d = count_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q   <= '0;
         div_q     <= CNT_WIDTH'(DEFAULT_DIV);
         tick_q    <= 1'b0;
         clk_out_q <= 1'b0;
         digit_q   <= '0;
      end else begin
         count_q   <= count_d;
         div_q     <= div_d;
         tick_q    <= tick_d;
         clk_out_q <= clk_out_d;
         digit_q   <= digit_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         bus.anode[i] = (digit_q != IDX_WIDTH'(i));
      end
   end

   assign bus.tick      = tick_q;
   assign bus.clk_out   = clk_out_q;
   assign bus.digit_idx = digit_q;

endmodule

// File: tb/tb_seg_scan_timer.sv
// Bench for seg_scan_timer: directed scenarios plus random traffic.
// Both instances are compared every cycle against a period/tick-count reference model.
module tb_seg_scan_timer;
   localparam int CW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_a, reset_b;
   int   errors = 0;
   int   checks = 0;

   seg_scan_timer_if #(.CNT_WIDTH(CW), .NUM_DIGITS(4), .IDX_WIDTH(2)) bus_a ();
   seg_scan_timer_if #(.CNT_WIDTH(CW), .NUM_DIGITS(3), .IDX_WIDTH(2)) bus_b ();

   seg_scan_timer #(.CNT_WIDTH(CW), .DEFAULT_DIV(4), .NUM_DIGITS(4), .IDX_WIDTH(2)) dut_a (
      .clk   (clk),
      .reset (reset_a),
      .bus   (bus_a)
   );

   seg_scan_timer #(.CNT_WIDTH(CW), .DEFAULT_DIV(1), .NUM_DIGITS(3), .IDX_WIDTH(2)) dut_b (
      .clk   (clk),
      .reset (reset_b),
      .bus   (bus_b)
   );

   // Reference model: the position inside the current period plus the number of periods completed.
   // clk_out is the parity of that period count, and digit is the period count modulo the digit count.
   int m_phase [2];
   int m_div   [2];
   int m_ticks [2];
   bit m_tick  [2];
   int ndig    [2] = '{4, 3};
   int defdiv  [2] = '{4, 1};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input int k, input bit rst, input bit ld, input int val, input bit en);
      if (!rst) begin
         m_phase[k] = 0; m_div[k] = defdiv[k]; m_ticks[k] = 0; m_tick[k] = 0;
      end else if (ld) begin
         m_div[k] = val; m_phase[k] = 0; m_tick[k] = 0;
      end else if (!en) begin
         m_tick[k] = 0;
      end else if (m_phase[k] == m_div[k]) begin
         m_phase[k] = 0; m_tick[k] = 1; m_ticks[k]++;
      end else begin
         m_phase[k]++; m_tick[k] = 0;
      end
   endtask

   function automatic logic [31:0] exp_anode(input int k);
      int d = m_ticks[k] % ndig[k];
      return ~(32'd1 << d) & ((32'd1 << ndig[k]) - 32'd1);
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step(0, reset_a, bus_a.div_load, int'(bus_a.div_value), bus_a.enable);
      model_step(1, reset_b, bus_b.div_load, int'(bus_b.div_value), bus_b.enable);
      #1;
      check("a.tick",    32'(bus_a.tick),      32'(m_tick[0]));
      check("a.clk_out", 32'(bus_a.clk_out),   32'(m_ticks[0] % 2));
      check("a.digit",   32'(bus_a.digit_idx), 32'(m_ticks[0] % 4));
      check("a.anode",   32'(bus_a.anode),     exp_anode(0));
      check("b.tick",    32'(bus_b.tick),      32'(m_tick[1]));
      check("b.clk_out", 32'(bus_b.clk_out),   32'(m_ticks[1] % 2));
      check("b.digit",   32'(bus_b.digit_idx), 32'(m_ticks[1] % 3));
      check("b.anode",   32'(bus_b.anode),     exp_anode(1));
   endtask

   // Returns the number of edges until tick is seen high, or -1 if the budget expires first.
   task automatic wait_tick(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         cycle();
         if (bus_a.tick) begin
            n = i;
            break;
         end
      end
   endtask

   int n;
   int r;
   logic [1:0] saved_digit;

   initial begin
      reset_a = 1'b0; reset_b = 1'b0;
      bus_a.enable = 1'b1; bus_a.div_load = 1'b0; bus_a.div_value = '0;
      bus_b.enable = 1'b1; bus_b.div_load = 1'b0; bus_b.div_value = '0;

      // Reset and default ratio (DEFAULT_DIV=4): period 5, scan 0,1,2,3,0
      cycle();
      check("rst.anode",   32'(bus_a.anode),     32'b1110);
      check("rst.digit",   32'(bus_a.digit_idx), 32'd0);
      check("rst.clk_out", 32'(bus_a.clk_out),   32'd0);
      check("rst.tick",    32'(bus_a.tick),      32'd0);
      reset_a = 1'b1; reset_b = 1'b1;
      wait_tick(20, n); check("def.first_tick", 32'(n), 32'd5);
      check("def.anode1", 32'(bus_a.anode), 32'b1101); check("def.clk1", 32'(bus_a.clk_out), 32'd1);
      wait_tick(20, n); check("def.period2", 32'(n), 32'd5);
      check("def.anode2", 32'(bus_a.anode), 32'b1011); check("def.clk2", 32'(bus_a.clk_out), 32'd0);
      wait_tick(20, n); check("def.period3", 32'(n), 32'd5);
      check("def.anode3", 32'(bus_a.anode), 32'b0111);
      wait_tick(20, n); check("def.period4", 32'(n), 32'd5);
      check("def.anode0", 32'(bus_a.anode), 32'b1110); check("def.digit0", 32'(bus_a.digit_idx), 32'd0);

      // Programmed ratio loaded mid-period
      cycle(); cycle();
      bus_a.div_load = 1'b1; bus_a.div_value = 16'd2;
      cycle();
      bus_a.div_load = 1'b0;
      wait_tick(20, n); check("div2.first", 32'(n), 32'd3);
      wait_tick(20, n); check("div2.period", 32'(n), 32'd3);

      // Divide-by-one: tick held high, clk_out toggles every clock
      bus_a.div_load = 1'b1; bus_a.div_value = 16'd0;
      cycle();
      bus_a.div_load = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         check("div0.tick", 32'(bus_a.tick), 32'd1);
      end

      // Enable gating with div=9: freeze at count 4, resume from there
      bus_a.div_load = 1'b1; bus_a.div_value = 16'd9;
      cycle();
      bus_a.div_load = 1'b0;
      repeat (4) cycle();
      bus_a.enable = 1'b0;
      for (int i = 0; i < 7; i++) begin
         cycle();
         check("gate.tick", 32'(bus_a.tick), 32'd0);
      end
      bus_a.enable = 1'b1;
      wait_tick(30, n); check("gate.resume", 32'(n), 32'(9 - 4 + 1));

      // Load coincident with the terminal edge wins
      bus_a.div_load = 1'b1; bus_a.div_value = 16'd3;
      cycle();
      bus_a.div_load = 1'b0;
      repeat (3) cycle();
      saved_digit = bus_a.digit_idx;
      bus_a.div_load = 1'b1; bus_a.div_value = 16'd3;
      cycle();
      bus_a.div_load = 1'b0;
      check("coll.no_tick",  32'(bus_a.tick),      32'd0);
      check("coll.no_adv",   32'(bus_a.digit_idx), 32'(saved_digit));
      wait_tick(20, n); check("coll.next", 32'(n), 32'd4);

      // Reset together with a load: reset wins and the default ratio returns
      reset_a = 1'b0; bus_a.div_load = 1'b1; bus_a.div_value = 16'd7;
      cycle();
      check("rstld.anode", 32'(bus_a.anode),     32'b1110);
      check("rstld.digit", 32'(bus_a.digit_idx), 32'd0);
      reset_a = 1'b1; bus_a.div_load = 1'b0;
      wait_tick(20, n); check("rstld.period", 32'(n), 32'd5);

      // Three-digit scan with div=1: anode 110,101,011 and index 3 never appears
      reset_b = 1'b0;
      cycle();
      reset_b = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         cycle();
         check("nd3.digit", 32'(bus_b.digit_idx), 32'((j / 2) % 3));
         check("nd3.anode", 32'(bus_b.anode),     ~(32'd1 << ((j / 2) % 3)) & 32'b111);
      end

      // Random traffic on instance A against the model
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 99));
         bus_a.enable    = (r >= 15);
         bus_a.div_load  = (r < 6);
         bus_a.div_value = 16'($urandom_range(0, 7));
         reset_a         = (r != 99);
         cycle();
      end
      reset_a = 1'b1; bus_a.div_load = 1'b0; bus_a.enable = 1'b1;
      repeat (10) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
